// File: rtl/nf10_upb_axis_length_monitor_if.sv
// AXI4-Stream bus bundle for the length monitor tap: master/slave views for the
// stream endpoints plus a passive all-input view for observers.
interface nf10_upb_axis_length_monitor_if #(
  parameter int unsigned axis_tkeep_width               = 32,
  parameter int unsigned axis_tuser_packet_length_width = 14
);
  logic                                      axis_tvalid;
  logic                                      axis_tready;
  logic [axis_tkeep_width-1:0]               axis_tkeep;
  logic                                      axis_tlast;
  logic [axis_tuser_packet_length_width-1:0] axis_tuser_packet_length;

  modport master (
    output axis_tvalid, axis_tkeep, axis_tlast, axis_tuser_packet_length,
    input  axis_tready
  );

  modport slave (
    input  axis_tvalid, axis_tkeep, axis_tlast, axis_tuser_packet_length,
    output axis_tready
  );

  modport monitor (
    input axis_tvalid, axis_tready, axis_tkeep, axis_tlast, axis_tuser_packet_length
  );
endinterface

// File: rtl/nf10_upb_axis_length_monitor.sv
// Passive AXI4-Stream tap: tracks packet boundaries, counts bytes from tkeep and
// flags length / tkeep / tuser-change errors for a ChipScope DATA/TRIG port.
module nf10_upb_axis_length_monitor #(
  parameter int unsigned axis_tkeep_width               = 32,
  parameter int unsigned axis_tuser_packet_length_width = 14,
  parameter int unsigned counter_width                  = 32
) (
  input  logic                                        clk,
  input  logic                                        resetn,
  nf10_upb_axis_length_monitor_if.monitor             axis,
  input  logic                                        clear,
  output logic                                        in_packet,
  output logic [axis_tuser_packet_length_width:0]     byte_count,
  output logic [axis_tuser_packet_length_width:0]     last_length,
  output logic [2:0]                                  error_vec,
  output logic                                        trig,
  output logic [counter_width-1:0]                    packet_count,
  output logic [counter_width-1:0]                    error_count
);

  localparam int unsigned LW = axis_tuser_packet_length_width;
  localparam int unsigned BW = LW + 1;
  localparam int unsigned KW = axis_tkeep_width;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PKT  = 1'b1;

  localparam logic [KW-1:0] KEEP_ONE = {{(KW-1){1'b0}}, 1'b1};

  logic [0:0]             state_q, state_d;
  logic [BW-1:0]          byte_count_q, byte_count_d;
  logic [BW-1:0]          last_length_q, last_length_d;
  logic [LW-1:0]          len_ref_q, len_ref_d;
  logic [2:0]             error_vec_q, error_vec_d;
  logic                   trig_q, trig_d;
  logic [counter_width-1:0] packet_count_q, packet_count_d;
  logic [counter_width-1:0] error_count_q, error_count_d;

  logic          beat;
  logic [BW-1:0] keep_ones;
  logic [BW-1:0] base;
  logic [BW:0]   sum;
  logic [BW-1:0] acc;
  logic [LW-1:0] len_eff;
  logic          keep_legal;

  assign beat = axis.axis_tvalid & axis.axis_tready;

  always_comb begin
    keep_ones = '0;
    for (int unsigned i = 0; i < KW; i++) begin
      keep_ones = keep_ones + BW'(axis.axis_tkeep[i]);
    end
  end

  // Legal tkeep is 2^n-1 with n>0: x & (x+1) is zero only for LSB-contiguous ones.
  always_comb begin
    keep_legal = (|axis.axis_tkeep) &&
                 ((axis.axis_tkeep & (axis.axis_tkeep + KEEP_ONE)) == '0) &&
                 (axis.axis_tlast || (&axis.axis_tkeep));
  end

  // A first beat starts from zero and compares against its own tuser value.
  assign base    = (state_q == IDLE) ? '0 : byte_count_q;
  assign len_eff = (state_q == IDLE) ? axis.axis_tuser_packet_length : len_ref_q;
  assign sum     = {1'b0, base} + {1'b0, keep_ones};
  assign acc     = sum[BW] ? '1 : sum[BW-1:0];

  always_comb begin
    state_d        = state_q;
    byte_count_d   = byte_count_q;
    last_length_d  = last_length_q;
    len_ref_d      = len_ref_q;
    error_vec_d    = '0;
    packet_count_d = packet_count_q;
    error_count_d  = error_count_q;

    if (beat) begin
      byte_count_d   = acc;
      error_vec_d[1] = ~keep_legal;
      if (state_q == IDLE) begin
        len_ref_d = axis.axis_tuser_packet_length;
      end else begin
        error_vec_d[2] = (axis.axis_tuser_packet_length != len_ref_q);
      end
      if (axis.axis_tlast) begin
        state_d        = IDLE;
        last_length_d  = acc;
        packet_count_d = packet_count_q + counter_width'(1);
        error_vec_d[0] = (acc != {1'b0, len_eff});
      end else begin
        state_d = PKT;
      end
    end

    if (trig_q && (error_count_q != '1)) begin
      error_count_d = error_count_q + counter_width'(1);
    end

    if (clear) begin
      packet_count_d = '0;
      error_count_d  = '0;
      last_length_d  = '0;
    end

    trig_d = |error_vec_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      byte_count_q   <= '0;
      last_length_q  <= '0;
      len_ref_q      <= '0;
      error_vec_q    <= '0;
      trig_q         <= 1'b0;
      packet_count_q <= '0;
      error_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      byte_count_q   <= byte_count_d;
      last_length_q  <= last_length_d;
      len_ref_q      <= len_ref_d;
      error_vec_q    <= error_vec_d;
      trig_q         <= trig_d;
      packet_count_q <= packet_count_d;
      error_count_q  <= error_count_d;
    end
  end

  assign in_packet    = (state_q == PKT);
  assign byte_count   = byte_count_q;
  assign last_length  = last_length_q;
  assign error_vec    = error_vec_q;
  assign trig         = trig_q;
  assign packet_count = packet_count_q;
  assign error_count  = error_count_q;

endmodule

// File: tb/tb_nf10_upb_axis_length_monitor.sv
// Scoreboard bench for nf10_upb_axis_length_monitor: a packet-level reference
// model predicts every cycle's outputs, a negedge monitor pops and compares.
module tb_nf10_upb_axis_length_monitor;

  localparam int unsigned KW = 32;
  localparam int unsigned LW = 14;
  localparam int unsigned CW = 32;
  localparam int unsigned BW = LW + 1;
  localparam int unsigned BC_MAX = (1 << BW) - 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic clear = 1'b0;

  logic          in_packet;
  logic [BW-1:0] byte_count;
  logic [BW-1:0] last_length;
  logic [2:0]    error_vec;
  logic          trig;
  logic [CW-1:0] packet_count;
  logic [CW-1:0] error_count;

  always #5 clk = ~clk;

  nf10_upb_axis_length_monitor_if #(
    .axis_tkeep_width              (KW),
    .axis_tuser_packet_length_width(LW)
  ) axis ();

  nf10_upb_axis_length_monitor #(
    .axis_tkeep_width              (KW),
    .axis_tuser_packet_length_width(LW),
    .counter_width                 (CW)
  ) u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .axis        (axis),
    .clear       (clear),
    .in_packet   (in_packet),
    .byte_count  (byte_count),
    .last_length (last_length),
    .error_vec   (error_vec),
    .trig        (trig),
    .packet_count(packet_count),
    .error_count (error_count)
  );

  typedef struct {
    logic [2:0]  ev;
    logic        trig;
    logic        inp;
    int unsigned bc;
    int unsigned ll;
    int unsigned pc;
    int unsigned ec;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: packet-level view of the tapped stream.
  bit          m_inpkt;
  int unsigned m_bytes, m_len, m_last, m_pc, m_ec;
  logic [2:0]  m_ev;
  bit          m_trig;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input int unsigned n);
    logic [32:0] one;
    one = 33'd1;
    return 32'((one << n) - 33'd1);
  endfunction

  task automatic model_reset();
    m_inpkt = 0; m_bytes = 0; m_len = 0; m_last = 0;
    m_pc = 0; m_ec = 0; m_ev = '0; m_trig = 0;
  endtask

  task automatic cyc(input bit v, input bit r, input logic [31:0] k, input bit l,
                     input int unsigned tu, input bit clr);
    exp_t        e;
    int unsigned n;
    bit          legal;
    logic [2:0]  ev;
    axis.axis_tvalid = v;
    axis.axis_tready = r;
    axis.axis_tkeep = k;
    axis.axis_tlast = l;
    axis.axis_tuser_packet_length = LW'(tu);
    clear = clr;
    ev = '0;
    if (clr) m_ec = 0;
    else if (m_trig && m_ec != 32'hFFFF_FFFF) m_ec++;
    if (v && r) begin
      n = $countones(k);
      legal = (n != 0) && (k == mask_of(n)) && (l || n == KW);
      ev[1] = !legal;
      if (!m_inpkt) begin
        m_len = tu;
        m_bytes = n;
      end else begin
        m_bytes = (m_bytes + n > BC_MAX) ? BC_MAX : m_bytes + n;
        ev[2] = (tu != m_len);
      end
      if (l) begin
        ev[0] = (m_bytes != m_len);
        m_last = m_bytes;
        m_pc++;
        m_inpkt = 0;
      end else begin
        m_inpkt = 1;
      end
    end
    if (clr) begin
      m_pc = 0;
      m_last = 0;
    end
    m_ev = ev;
    m_trig = |ev;
    e.ev = m_ev; e.trig = m_trig; e.inp = m_inpkt; e.bc = m_bytes;
    e.ll = m_last; e.pc = m_pc; e.ec = m_ec;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic send(input logic [31:0] k, input bit l, input int unsigned tu);
    cyc(1, 1, k, l, tu, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 resetn = 1'b0;
    model_reset();
    axis.axis_tvalid = 0; axis.axis_tready = 0; axis.axis_tkeep = '0;
    axis.axis_tlast = 0; axis.axis_tuser_packet_length = '0; clear = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 resetn = 1'b1;
  endtask

  function automatic logic [31:0] rand_keep();
    int unsigned sel;
    sel = $urandom_range(0, 99);
    if (sel < 60) return '1;
    if (sel < 85) return mask_of($urandom_range(1, 31));
    if (sel < 95) return $urandom;
    return '0;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("error_vec", 64'(error_vec), 64'(e.ev));
      chk("trig", 64'(trig), 64'(e.trig));
      chk("in_packet", 64'(in_packet), 64'(e.inp));
      chk("byte_count", 64'(byte_count), 64'(e.bc));
      chk("last_length", 64'(last_length), 64'(e.ll));
      chk("packet_count", 64'(packet_count), 64'(e.pc));
      chk("error_count", 64'(error_count), 64'(e.ec));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cur_tu;
    int          inpk_cycles;
    model_reset();
    axis.axis_tvalid = 0; axis.axis_tready = 0; axis.axis_tkeep = '0;
    axis.axis_tlast = 0; axis.axis_tuser_packet_length = '0;
    #12 resetn = 1'b1;
    idle(2);

    // 3-beat 68-byte packet
    inpk_cycles = 0;
    send(32'hFFFF_FFFF, 0, 68); inpk_cycles += int'(in_packet);
    send(32'hFFFF_FFFF, 0, 68); inpk_cycles += int'(in_packet);
    send(32'h0000_000F, 1, 68); inpk_cycles += int'(in_packet);
    chk("tp1_last_length", 64'(last_length), 64'd68);
    chk("tp1_packet_count", 64'(packet_count), 64'd1);
    chk("tp1_in_packet_cycles", 64'(inpk_cycles), 64'd2);
    idle(2);

    // single beat, length mismatch
    do_reset();
    send(32'h0000_00FF, 1, 10);
    chk("tp2_error_vec", 64'(error_vec), 64'h1);
    chk("tp2_in_packet", 64'(in_packet), 64'd0);
    idle(1);
    chk("tp2_error_count", 64'(error_count), 64'd1);
    chk("tp2_last_length", 64'(last_length), 64'd8);

    // tkeep violations on a middle and a last beat
    do_reset();
    send(32'hFFFF_FFFF, 0, 65);
    send(32'h7FFF_FFFF, 0, 65);
    chk("tp3_mid_keep_err", 64'(error_vec), 64'h2);
    send(32'h0000_0005, 1, 65);
    chk("tp3_last_keep_err", 64'(error_vec), 64'h2);
    idle(1);
    chk("tp3_error_count", 64'(error_count), 64'd2);

    // tuser change mid-packet
    send(32'hFFFF_FFFF, 0, 64);
    send(32'hFFFF_FFFF, 1, 65);
    chk("tp4_error_vec", 64'(error_vec), 64'h4);

    // stalled beats ignored, then clear coinciding with a tlast increment
    do_reset();
    send(32'hFFFF_FFFF, 0, 96);
    for (int i = 0; i < 5; i++) cyc(1, 0, rand_keep(), 1'($urandom), $urandom_range(0, 300), 0);
    send(32'hFFFF_FFFF, 0, 96);
    send(32'hFFFF_FFFF, 1, 96);
    chk("tp5_last_length", 64'(last_length), 64'd96);
    chk("tp5_trig", 64'(trig), 64'd0);
    cyc(1, 1, 32'hFFFF_FFFF, 1, 32, 1);
    chk("tp5_clear_packet_count", 64'(packet_count), 64'd0);
    idle(1);

    // reset mid-packet, then a clean 1-beat packet
    send(32'hFFFF_FFFF, 0, 200);
    send(32'hFFFF_FFFF, 0, 200);
    do_reset();
    idle(1);
    send(32'hFFFF_FFFF, 1, 32);
    chk("tp6_error_vec", 64'(error_vec), 64'h0);
    chk("tp6_last_length", 64'(last_length), 64'd32);
    chk("tp6_packet_count", 64'(packet_count), 64'd1);

    // back-to-back packets without idle cycles
    for (int p = 0; p < 6; p++) begin
      int unsigned nb;
      nb = $urandom_range(1, 4);
      for (int unsigned b = 0; b < nb; b++)
        send((b == nb - 1) ? mask_of($urandom_range(1, 32)) : 32'hFFFF_FFFF,
             b == nb - 1, $urandom_range(1, 128));
    end

    // byte_count saturation on an oversized packet
    for (int i = 0; i < 1100; i++) send(32'hFFFF_FFFF, 0, 100);
    chk("sat_byte_count", 64'(byte_count), 64'(BC_MAX));
    send(32'hFFFF_FFFF, 1, 100);
    chk("sat_length_err", 64'(error_vec[0]), 64'd1);
    idle(2);

    // randomized traffic
    cur_tu = $urandom_range(1, 200);
    for (int i = 0; i < 600; i++) begin
      bit v, r, l;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      if (!m_inpkt && $urandom_range(0, 1) == 0) cur_tu = $urandom_range(1, 200);
      else if (m_inpkt && $urandom_range(0, 19) == 0) cur_tu = $urandom_range(1, 200);
      cyc(v, r, rand_keep(), l, cur_tu, $urandom_range(0, 39) == 0);
    end

    idle(3);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nf10_upb_axis_length_monitor.md
# nf10_upb_axis_length_monitor

Passive AXI4-Stream tap that sits directly upstream of the stream ChipScope core on the same bus. It tracks packet boundaries and counts the bytes in each packet from tkeep. It checks each packet against the tuser packet-length field and the tkeep encoding rules, and produces registered error pulses, a trigger, and statistics counters for the ChipScope core's DATA/TRIG inputs. It never drives tready and never alters the monitored stream.

## Interface
Parameters:
- axis_tkeep_width, 32: tkeep width, i.e. bytes per beat.
- axis_tuser_packet_length_width, 14: width of the tuser packet-length field (bytes).
- counter_width, 32: width of the packet and error counters.

Ports:
- clk  in  1  single clock.
- resetn  in  1  asynchronous, active-low reset.
- axis_tvalid  in  1  tapped tvalid.
- axis_tready  in  1  tapped tready.
- axis_tkeep  in  axis_tkeep_width  tapped tkeep.
- axis_tlast  in  1  tapped tlast.
- axis_tuser_packet_length  in  axis_tuser_packet_length_width  tapped tuser length field.
- clear  in  1  synchronous clear of the statistics counters.
- in_packet  out  1  high between the first and last beat of a packet.
- byte_count  out  axis_tuser_packet_length_width+1  running byte count of the current packet, saturating.
- last_length  out  axis_tuser_packet_length_width+1  byte count of the last completed packet.
- error_vec  out  3  registered pulses: [0] length mismatch, [1] tkeep error, [2] tuser change mid-packet.
- trig  out  1  OR of error_vec.
- packet_count  out  counter_width  completed packets, wrapping.
- error_count  out  counter_width  cycles with trig asserted, saturating.

## Operation
- A beat is a cycle with tvalid & tready. All other cycles leave every state unchanged except the error pulses, which return to 0.
- FSM has two states, IDLE and PKT. in_packet = (state == PKT).
- IDLE, on a beat:
  - latch len_ref = tuser_packet_length;
  - set byte_count = popcount(tkeep);
  - go to PKT if tlast = 0; stay in IDLE if tlast = 1 (single-beat packet).
- PKT, on a beat: byte_count += popcount(tkeep), saturating at all-ones. On tlast, return to IDLE.
- tkeep is legal only if it is nonzero and contiguous from the LSB, i.e. of the form 2^n-1.
  - A non-last beat additionally requires all ones.
  - A violation sets error_vec[1] for that beat.
- tuser change: a PKT-state beat with tuser_packet_length != len_ref sets error_vec[2].
- On a tlast beat:
  - final = the accumulated count including this beat;
  - last_length <= final;
  - packet_count += 1 (wraps);
  - error_vec[0] = (final != zero-extended len_ref). For a single-beat packet, len_ref is the current tuser value.
- Several error bits can assert in the same cycle. error_count increments by 1 per trig cycle, not per bit, and saturates at all-ones.
- clear: packet_count, error_count and last_length go to 0. When clear and an increment coincide, clear wins. clear does not affect the FSM, byte_count or len_ref.
- A tvalid/tlast/tkeep value without tready is ignored entirely.

## Timing
- All outputs are registered.
- error_vec and trig pulse for exactly one cycle, in the cycle after the offending beat.
- byte_count, last_length, packet_count and in_packet update in the cycle after the beat.
- error_count updates one cycle after trig, i.e. two cycles after the beat.
- Reset values: state IDLE, in_packet 0, byte_count 0, last_length 0, error_vec 0, trig 0, packet_count 0, error_count 0, len_ref 0.
- Reset assertion mid-packet returns to IDLE immediately. After deassertion, the next beat is treated as a first beat. No mismatch is reported for the aborted packet.
- Back-to-back packets: a tlast beat followed by a beat in the next cycle. The new packet starts cleanly: byte_count restarts at that beat's popcount and nothing accumulates across packets.

## Test plan
- Packet of 3 beats (tkeep FFFFFFFF, FFFFFFFF, 0000000F), tuser length 68 on all beats -> last_length 68, packet_count 1, trig never high, in_packet high for 2 cycles.
- Single beat, tkeep 000000FF, tuser 10 -> error_vec = 3'b001 one cycle after the beat, error_count 1 one cycle later, last_length 8, in_packet stays 0.
- Middle beat with tkeep 7FFFFFFF, plus a last beat with tkeep 00000005, in one packet -> error_vec[1] pulses after each of those beats, error_count 2.
- tuser changes from 64 to 65 on beat 2 of a 2-beat 64-byte packet -> error_vec = 3'b100 after beat 2, no length error.
- Hold tvalid with tready low for 5 cycles with varied tkeep/tlast, then complete the packet -> only the accepted beats are counted and the result is correct. Assert clear on the same cycle as a tlast increment -> packet_count 0.
- Drop resetn mid-packet after 2 beats, release, then send a 1-beat 32-byte packet with tuser 32 -> no error, last_length 32, packet_count 1.
